tawas_dmem: RTL and testbench

Single-cycle-latency data memory that answers the Tawas core's no-wait D-bus. It accepts the registered `dcs`/`dwr`/`daddr`/`dmask`/`dout` requests from the load/store unit and returns read data on `din` exactly one cycle later. It zero-fills itself after reset and flags out-of-range accesses. It sits beside the core as the local data RAM for the low half of the address map; the RCN space (`addr[31]=1`) is never routed here.

---
 rtl/tawas_pkg.sv | 13 +
 rtl/tawas_dmem_array.sv | 30 +++
 rtl/tawas_dmem.sv | 130 +++++++++++++
 tb/tb_tawas_dmem.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tawas_pkg.sv
// Shared Tawas definitions: D-bus widths and the data-memory FSM state encoding.
package tawas_pkg;

  localparam int DBUS_AW = 32;
  localparam int DBUS_DW = 32;
  localparam int DBUS_MW = 4;

  typedef enum logic {
    DMEM_CLEAR = 1'b0,
    DMEM_READY = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/tawas_dmem_array.sv
// Plain single-port byte-enable RAM with registered read data and no reset.
// Written in the shape synthesis tools infer as block RAM.
module tawas_dmem_array
  import tawas_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DBUS_MW-1:0] wmask,
  input  logic [DBUS_DW-1:0] wdata,
  output logic [DBUS_DW-1:0] rdata
);

  logic [DBUS_DW-1:0] mem [2**ADDR_W];

  // Byte-lane writes and a registered read of the addressed word every cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DBUS_MW; i++) begin
        if (wmask[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/tawas_dmem.sv
// Tawas local data RAM on the no-wait D-bus. Answers loads one cycle after
// the request, zero-fills itself after reset, and reports out-of-range accesses.
module tawas_dmem
  import tawas_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dcs,
  input  logic               dwr,
  input  logic [DBUS_AW-1:0] daddr,
  input  logic [DBUS_MW-1:0] dmask,
  input  logic [DBUS_DW-1:0] dout,
  output logic [DBUS_DW-1:0] din,
  output logic               ready,
  output logic               err,
  output logic [DBUS_AW-1:0] err_addr,
  input  logic               err_clr
);

  localparam int CNT_W = ADDR_W + 1;
  // The counter runs one past the last word so the terminal count is visible
  // without wrapping back to zero.
  localparam logic [CNT_W-1:0] CLR_DONE = {1'b1, {ADDR_W{1'b0}}};

  dmem_state_t        state;
  logic [CNT_W-1:0]   clr_cnt;
  logic               armed;
  logic               load_q;
  logic               in_range;
  logic               bus_ok;
  logic               bus_bad;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DBUS_MW-1:0] ram_mask;
  logic [DBUS_DW-1:0] ram_wdata;
  logic [DBUS_DW-1:0] ram_rdata;
  logic               unused_addr_bits;

  // Bit 31 selects the RCN space and never reaches this block; bits 1:0 are byte offset.
  assign unused_addr_bits = ^{daddr[DBUS_AW-1], daddr[1:0]};

  assign in_range = (daddr[DBUS_AW-2:ADDR_W+2] == '0);
  assign bus_ok   = dcs & ready & in_range;
  assign bus_bad  = dcs & ready & ~in_range;

  // The clear counter owns the RAM port while clearing; the bus owns it afterwards.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = daddr[ADDR_W+1:2];
    ram_mask  = dmask;
    ram_wdata = dout;
    if (state == DMEM_CLEAR) begin
      ram_we    = ~clr_cnt[ADDR_W];
      ram_addr  = clr_cnt[ADDR_W-1:0];
      ram_mask  = '1;
      ram_wdata = '0;
    end else begin
      ram_we    = bus_ok & dwr;
    end
  end

  tawas_dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wmask (ram_mask),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Clear/ready FSM: walk every word once, then serve the bus until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR_ON_RESET ? DMEM_CLEAR : DMEM_READY;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        DMEM_CLEAR: begin
          if (clr_cnt == CLR_DONE) begin
            state <= DMEM_READY;
            ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        DMEM_READY: begin
          ready <= 1'b1;
        end
        default: begin
          state <= DMEM_CLEAR;
        end
      endcase
    end
  end

  // Remember which cycles carry load data and pulse err after an out-of-range request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q <= 1'b0;
      err    <= 1'b0;
    end else begin
      load_q <= bus_ok & ~dwr;
      err    <= bus_bad;
    end
  end

  // Sticky capture of the first bad address; a clear in the same cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_addr <= '0;
      armed    <= 1'b1;
    end else if (err_clr) begin
      err_addr <= '0;
      armed    <= 1'b1;
    end else if (bus_bad && armed) begin
      err_addr <= {daddr[DBUS_AW-1:2], 2'b00};
      armed    <= 1'b0;
    end
  end

  // Read data is only driven in the cycle after an accepted load, never stale.
  assign din = load_q ? ram_rdata : '0;

endmodule

// File: tb/tb_tawas_dmem.sv
// Directed bench for tawas_dmem: a 16-word clearing instance and a 4K-word
// instance that starts ready without clearing.
module tb_tawas_dmem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dcs_a;
  logic        dcs_b;
  logic        dwr;
  logic [31:0] daddr;
  logic [3:0]  dmask;
  logic [31:0] dout;
  logic        err_clr;

  logic [31:0] din_a;
  logic        ready_a;
  logic        err_a;
  logic [31:0] err_addr_a;
  logic [31:0] din_b;
  logic        ready_b;
  logic        err_b;
  logic [31:0] err_addr_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tawas_dmem #(
    .ADDR_W         (4),
    .CLEAR_ON_RESET (1'b1)
  ) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .dcs      (dcs_a),
    .dwr      (dwr),
    .daddr    (daddr),
    .dmask    (dmask),
    .dout     (dout),
    .din      (din_a),
    .ready    (ready_a),
    .err      (err_a),
    .err_addr (err_addr_a),
    .err_clr  (err_clr)
  );

  tawas_dmem #(
    .ADDR_W         (12),
    .CLEAR_ON_RESET (1'b0)
  ) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .dcs      (dcs_b),
    .dwr      (dwr),
    .daddr    (daddr),
    .dmask    (dmask),
    .dout     (dout),
    .din      (din_b),
    .ready    (ready_b),
    .err      (err_b),
    .err_addr (err_addr_b),
    .err_clr  (1'b0)
  );

  // Count a comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Drive one bus cycle at the falling edge; outputs seen at the next call reflect it.
  task automatic applyStimulus(input bit to_b, input bit cs, input bit wr, input logic [31:0] addr,
                               input logic [3:0] mask, input logic [31:0] data, input bit clr);
    @(negedge clk);
    dcs_a   = cs & ~to_b;
    dcs_b   = cs & to_b;
    dwr     = wr;
    daddr   = addr;
    dmask   = mask;
    dout    = data;
    err_clr = clr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    dcs_a   = 1'b0;
    dcs_b   = 1'b0;
    dwr     = 1'b0;
    daddr   = 32'h0;
    dmask   = 4'h0;
    dout    = 32'h0;
    err_clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dut_a.u_array.mem[i] = 32'hFFFF_FFFF;
    end

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_ready_a", 32'(ready_a), 32'd0);
    checkOutput("rst_ready_b", 32'(ready_b), 32'd0);
    checkOutput("rst_din_a", din_a, 32'h0);
    checkOutput("rst_err_a", 32'(err_a), 32'd0);
    checkOutput("rst_err_addr_a", err_addr_a, 32'h0);
    rst_n = 1'b1;

    // Clear duration and no-clear readiness
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        checkOutput("noclr_ready_edge1", 32'(ready_b), 32'd1);
        checkOutput("clr_ready_edge1", 32'(ready_a), 32'd0);
      end
      if (k == 16) checkOutput("clr_ready_edge16", 32'(ready_a), 32'd0);
      if (k == 17) checkOutput("clr_ready_edge17", 32'(ready_a), 32'd1);
    end

    // Every word was zeroed over the preloaded ones
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0, 1'b0);
      if (i > 0) checkOutput($sformatf("clear_word%0d", i - 1), din_a, 32'h0);
    end
    idle();
    checkOutput("clear_word15", din_a, 32'h0);

    // Store then load of the same word on consecutive cycles
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hCAFE_F00D, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    checkOutput("b2b_din_after_store", din_a, 32'h0);
    idle();
    checkOutput("b2b_din_after_load", din_a, 32'hCAFE_F00D);
    idle();
    checkOutput("b2b_din_idle", din_a, 32'h0);

    // Out-of-range load, sticky capture, clear and recapture
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
    idle();
    checkOutput("oor_din", din_a, 32'h0);
    checkOutput("oor_err", 32'(err_a), 32'd1);
    checkOutput("oor_err_addr", err_addr_a, 32'h100);
    idle();
    checkOutput("oor_err_pulse_end", 32'(err_a), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0, 1'b0);
    idle();
    checkOutput("oor2_err", 32'(err_a), 32'd1);
    checkOutput("oor2_err_addr_sticky", err_addr_a, 32'h100);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    idle();
    checkOutput("err_clr_zero", err_addr_a, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h204, 4'hF, 32'h1234_5678, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b0);
    checkOutput("oor_store_err_addr", err_addr_a, 32'h204);
    idle();
    checkOutput("oor_store_dropped", din_a, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 4'h0, 32'h0, 1'b1);
    idle();
    checkOutput("clr_wins_err", 32'(err_a), 32'd1);
    checkOutput("clr_wins_err_addr", err_addr_a, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h400, 4'h0, 32'h0, 1'b0);
    idle();
    checkOutput("rearm_err_addr", err_addr_a, 32'h400);

    // Reset from READY drops ready at once, then a second reset lands mid-clear
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ready", 32'(ready_a), 32'd0);
    checkOutput("async_rst_err_addr", err_addr_a, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) idle();
    rst_n = 1'b0;
    #1;
    checkOutput("midclr_rst_ready", 32'(ready_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      if (k >= 9 && k <= 14) applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
      else if (k == 15) applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
      else idle();
      if (k == 16) begin
        checkOutput("midclr_load_ignored", din_a, 32'h0);
        checkOutput("midclr_no_err", 32'(err_a), 32'd0);
        checkOutput("midclr_ready_edge16", 32'(ready_a), 32'd0);
      end
      if (k == 17) checkOutput("midclr_ready_edge17", 32'(ready_a), 32'd1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    checkOutput("midclr_store_dropped", din_a, 32'h0);
    idle();
    checkOutput("midclr_full_reclear", din_a, 32'h0);

    // No-clear instance: plain store/load and byte-lane merging
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h8, 4'hF, 32'hA5A5_1234, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0);
    idle();
    checkOutput("noclr_load", din_b, 32'hA5A5_1234);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 4'hF, 32'h1122_3344, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 4'h4, 32'hAAAA_AAAA, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 4'h3, 32'h5555_5555, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    checkOutput("lanes_din_before", din_b, 32'h0);
    idle();
    checkOutput("lanes_merge", din_b, 32'h11AA_5555);
    checkOutput("noclr_no_err", 32'(err_b), 32'd0);
    checkOutput("noclr_err_addr", err_addr_b, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
